// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
// Optional debounce is selected with COUNTER_RUN_CONTROLLER_DEBOUNCE_EN.
package counter_ctrl_pkg;

    localparam int COUNTER_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // Prescaler needs at least one bit even when PRESCALE is 2.
    function automatic int presc_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/counter_run_controller_button_conditioner.sv
// Raw button -> 2-flop synchroniser -> optional debouncer -> single-cycle rising-edge pulse.
// Debouncer present only when COUNTER_RUN_CONTROLLER_DEBOUNCE_EN is defined.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

`ifdef COUNTER_RUN_CONTROLLER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync_2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level  <= sync_2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/counter_run_controller.sv
// Run/step/stop sequencer producing paced count_en pulses for an 8-bit counter.
// Define COUNTER_RUN_CONTROLLER_DEBOUNCE_EN to debounce the three buttons.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE        = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int LIMIT_W         = 8
) (
    input  logic               clock_signal,
    input  logic               reset_signal_n,
    input  logic               btn_start,
    input  logic               btn_stop,
    input  logic               btn_step,
    input  logic [LIMIT_W-1:0] limit_value,
    input  logic               limit_stop,
    input  logic [LIMIT_W-1:0] counter_value,
    output logic               count_en,
    output logic               running,
    output logic               done,
    output logic [1:0]         state
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 2 || PRESCALE > 65535 || LIMIT_W != COUNTER_W) begin : g_bad_param
        $error("counter_run_controller: illegal PRESCALE or LIMIT_W");
    end

    ctrl_state_t    cur_state;
    ctrl_state_t    nxt_state;
    logic           cen_next;
    logic           guard;
    logic [PW-1:0]  presc;
    logic           start_p;
    logic           stop_p;
    logic           step_p;
    logic           at_limit;
    logic           tick;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clock_signal), .rst_n(reset_signal_n), .raw(btn_start), .pulse(start_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clock_signal), .rst_n(reset_signal_n), .raw(btn_stop), .pulse(stop_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clock_signal), .rst_n(reset_signal_n), .raw(btn_step), .pulse(step_p)
    );

    assign at_limit = limit_stop && (counter_value == limit_value);
    assign tick     = (presc == PRESC_LAST);
    assign state    = cur_state;

    // Command priority within a cycle: stop, then start, then step.
    always_comb begin
        nxt_state = cur_state;
        cen_next  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (!stop_p) begin
                    if (start_p)     nxt_state = at_limit ? DONE : RUN;
                    else if (step_p) nxt_state = STEP;
                end
            end
            RUN: begin
                if (stop_p) begin
                    nxt_state = IDLE;
                end else if (tick && !guard) begin
                    if (at_limit) nxt_state = DONE;
                    else          cen_next  = 1'b1;
                end
            end
            STEP: begin
                if (stop_p) begin
                    nxt_state = IDLE;
                end else if (at_limit) begin
                    nxt_state = DONE;
                end else begin
                    cen_next  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            DONE: begin
                if (stop_p) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_signal) begin
        if (!reset_signal_n) begin
            cur_state <= IDLE;
            count_en  <= 1'b0;
            guard     <= 1'b0;
            presc     <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            count_en  <= cen_next;
            guard     <= count_en;
            presc     <= (cur_state != RUN || tick) ? '0 : presc + 1'b1;
            running   <= (nxt_state == RUN);
            done      <= (nxt_state == DONE);
        end
    end

endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
- Sequencer that drives the `switch` enable input of the 8-bit counter.
- Turns raw start/stop/step buttons into clean single-cycle commands.
- Paces increments with a programmable prescaler and halts the count at a configurable limit.
- Sits between board buttons and the counter; reads the counter value back to detect the limit.

Parameters:
- PRESCALE, 4: clock cycles between increments in RUN; legal range 2..65535.
- DEBOUNCE_CYCLES, 3: consecutive stable samples needed to accept a button level; only used with DEBOUNCE_EN.
- LIMIT_W, 8: width of the limit compare; must equal the counter width.

Ports:
- clock_signal  in  1  single system clock; everything is posedge.
- reset_signal_n  in  1  synchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous.
- btn_stop  in  1  raw stop button, asynchronous.
- btn_step  in  1  raw single-step button, asynchronous.
- limit_value  in  LIMIT_W  terminal count.
- limit_stop  in  1  1: halt at limit; 0: free-run with wrap.
- counter_value  in  LIMIT_W  current counter output.
- count_en  out  1  drives counter `switch`; one cycle high = one increment.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- state  out  2  IDLE=0, RUN=1, STEP=2, DONE=3.

Behaviour:
- Reset:
  - Taken when reset_signal_n is low at a posedge.
  - state=IDLE; count_en=0; running=0; done=0; prescaler=0; guard=0; synchronisers and debouncers cleared to 0.
  - Reset mid-RUN aborts at the next edge. No count_en is issued in the reset cycle.
- Input conditioning:
  - Each button goes through a 2-flop synchroniser, then an optional debounce, then a rising-edge detect.
  - Result is a 1-cycle pulse: start_p, stop_p or step_p.
  - Latency from raw edge to pulse: 3 cycles without debounce; 3+DEBOUNCE_CYCLES with debounce.
- Guard flag:
  - Set the cycle after count_en=1, then cleared.
  - count_en is never high two consecutive cycles, so counter_value is always current when compared.
- Command priority, same cycle: stop_p > start_p > step_p.
- IDLE:
  - stop_p: no effect.
  - start_p: go to RUN, or to DONE if limit_stop=1 and counter_value==limit_value.
  - step_p: go to STEP.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and is cleared on entry to RUN.
  - tick = prescaler==PRESCALE-1.
  - On tick with guard=0: if limit_stop=1 and counter_value==limit_value, go to DONE with no pulse; otherwise count_en=1 for that cycle.
  - First pulse occurs PRESCALE cycles after entering RUN.
  - stop_p: go to IDLE immediately; no count_en that cycle.
  - limit_stop=0: counter wraps 255->0 naturally; the controller keeps running.
- STEP:
  - If limit_stop=1 and counter_value==limit_value: go to DONE, no pulse.
  - Otherwise count_en=1 for exactly one cycle, then IDLE.
  - stop_p in STEP: go to IDLE, no pulse.
- DONE:
  - done=1, count_en=0.
  - start_p and step_p are ignored.
  - stop_p: go to IDLE.
  - limit_value changed to differ from counter_value: stay in DONE until stop.
- Outputs running, done and state are registered and reflect the current state.
- count_en is registered; the counter sees it at the next posedge.

Optional Feature:
- Macro: COUNTER_RUN_CONTROLLER_DEBOUNCE_EN.
- Defined: each synchronised button passes through a debouncer. The output level changes only after DEBOUNCE_CYCLES consecutive identical samples. Glitches shorter than that are rejected.
- Undefined: the synchronised level feeds edge detect directly. Debouncer logic is absent and the DEBOUNCE_CYCLES parameter is unused.

Decomposition:
- Shared package counter_ctrl_pkg:
  - state enum: IDLE, RUN, STEP, DONE (2 bits).
  - Constant COUNTER_W=8.
  - Prescaler width derived as clog2(PRESCALE).
- One sub-module: button_conditioner. It contains the synchroniser, the optional debouncer and the edge detect. It is instantiated three times.

Test Plan:
- Reset: hold reset_signal_n=0 for 2 cycles with buttons toggling -> state=0, count_en=0, done=0. After release with no buttons pressed, no count_en ever appears.
- Run to limit: limit_value=5, limit_stop=1, counter starting at 0, PRESCALE=4, press start -> exactly 5 count_en pulses spaced 4 cycles apart. When counter_value==5, state goes to DONE and done=1. count_en stays 0 afterward.
- Free-run wrap: limit_stop=0, counter preset to 254, RUN -> counter goes 254->255->0->1, running stays 1, done stays 0.
- Step: in IDLE with counter=10, press step -> exactly one count_en cycle, counter=11, state returns to IDLE. Step pressed in DONE -> no pulse.
- Priority and abort: start and stop pulses in the same cycle from IDLE -> stays IDLE. Stop asserted in RUN one cycle before a tick -> no pulse is issued and state goes to IDLE.
- Debounce (macro defined, DEBOUNCE_CYCLES=3): 2-cycle glitch on btn_start -> no start_p. Clean press held for 5 cycles -> exactly one start_p, and RUN is entered.
